sram_arbiter: RTL
=================

# sram_arbiter

Two-port arbiter and sequencer for the single 16-bit external SRAM. It shares the chip between the instruction-fetch port (read-only) and the MEM-stage data port (read/write), and splits every 32-bit access into two 16-bit SRAM transactions with programmable wait states. Per-port stall outputs feed the pipeline freeze logic, in the same role as `SRAM_NOT_READY`.

## Interface
- `WAIT_CYCLES`, default 1: cycles each 16-bit half is held on the bus; legal range 1..15.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  instruction read request, level; held with `i_addr` until `i_ready`.
- `i_addr`  in  32  instruction byte address; bits [1:0] ignored.
- `i_rdata`  out  32  instruction word; valid while `i_ready`=1, held until the next instruction completion.
- `i_ready`  out  1  one-cycle completion pulse.
- `i_stall`  out  1  `i_req & ~i_ready` (combinational).
- `d_rd`  in  1  data read request, level.
- `d_wr`  in  1  data write request, level; wins over `d_rd` if both are 1.
- `d_addr`  in  32  data byte address; bits [1:0] ignored.
- `d_wdata`  in  32  write data, held stable until `d_ready`.
- `d_rdata`  out  32  read word; valid with `d_ready`, held until the next data read completion.
- `d_ready`  out  1  one-cycle completion pulse.
- `d_stall`  out  1  `(d_rd|d_wr) & ~d_ready` (combinational).
- `SRAMaddress`  out  18  halfword address `{addr[18:2], half}`.
- `SRAMWEn`  out  1  active-low write enable.
- `SRAMdata`  inout  16  driven only during write phases, high-Z otherwise.

## Operation
- **FSM states:** IDLE, LO, HI, DONE.
- **IDLE:**
  - Samples requests.
  - Latches the winner's port id, address, write flag and write data.
  - Loads wait counter `cnt`=0.
  - Goes to LO.
  - Stays in IDLE if there is no request.
- **Arbitration:** round-robin on a `last` flag, reset value = instruction.
  - If both ports request, the grant goes to the port not equal to `last`.
  - A single requester always wins.
  - `last` updates on grant.
- **LO phase:**
  - `SRAMaddress` = `{addr[18:2],1'b0}`.
  - For a write: drive `wdata[15:0]` and hold `SRAMWEn`=0 for all `WAIT_CYCLES` cycles.
  - For a read: capture `SRAMdata` into `rbuf[15:0]` when `cnt`==`WAIT_CYCLES`-1.
  - `cnt` increments every cycle. At `WAIT_CYCLES`-1 it clears and the FSM goes to HI.
- **HI phase:**
  - Same as LO with half bit = 1 and bits [31:16].
  - At the end goes to DONE.
- **DONE (one cycle):**
  - Pulses the granted port's ready.
  - For a read, the port's rdata register loads `rbuf` at the end of HI, so it is valid during DONE.
  - `SRAMWEn`=1, bus at high-Z.
  - Next state IDLE.
- **Request changes:** requests that change while not granted have no effect. Requesters must not change operands before ready.
- **Write/read precedence:** a write with `d_rd`=1 performs a write only. `d_rdata` is unchanged by writes.
- **Bus drive:** `SRAMdata` is driven iff state ∈ {LO,HI} and the grant is a write.
- **Address wrap:** address bits above 18 are ignored, so addresses wrap modulo 512 KiB.

## Timing
- **Reset values:**
  - State IDLE.
  - `i_ready`=`d_ready`=0.
  - `i_rdata`=`d_rdata`=0.
  - `SRAMaddress`=0, `SRAMWEn`=1, `SRAMdata`=Z.
  - `last`=instruction.
  - `cnt`=0.
- **Latency:** request seen at edge 0 in IDLE gives ready at cycle 2·`WAIT_CYCLES`+1. With `WAIT_CYCLES`=1, ready is asserted 3 cycles after the request. Each access occupies 2·`WAIT_CYCLES`+2 cycles.
- **Back-to-back:** a request held or re-asserted through DONE is sampled in the following IDLE cycle; no request is sampled in DONE.
- **Reset mid-access:** asynchronous abort.
  - `SRAMWEn` goes to 1 and the bus to high-Z immediately.
  - Half-written words are not completed.
  - No ready pulse is issued.
- **Write-enable timing:** `SRAMWEn` never goes low in IDLE or DONE. The address is stable for the whole phase in which `SRAMWEn`=0.
- **Stall outputs:** combinational from inputs and the ready registers, with no extra latency.

## Test plan
- **Reset values:** assert `rst`=0 mid-LO of a write → `SRAMWEn`=1 and `SRAMdata`=Z in the same cycle, state IDLE, no ready pulse. Release `rst` → idle until a request arrives.
- **Single data write:** `WAIT_CYCLES`=1, `d_wr`, `d_addr`=0x0000_0010, `d_wdata`=0xDEAD_BEEF.
  - Expect `SRAMaddress`=0x00008 with data 0xBEEF, then 0x00009 with 0xDEAD.
  - `SRAMWEn`=0 exactly 2 cycles.
  - `d_ready` pulses at cycle 3; `d_stall` is 1 for cycles 0–2.
- **Read back:** `d_rd` at 0x10 with a SRAM model → `d_rdata`=0xDEAD_BEEF during the `d_ready` pulse, held afterward. `i_rdata` is unchanged.
- **Contention:**
  - Both ports request continuously from reset → grants alternate D, I, D, I.
  - `i_ready` and `d_ready` are never both 1.
  - Each access takes 4 cycles.
- **Wait states:** `WAIT_CYCLES`=3, `i_req` at `i_addr`=0x0003_FFFC → `SRAMaddress` 0x1FFFE for 3 cycles, then 0x1FFFF for 3 cycles. `i_ready` at cycle 7.
- **Read/write conflict:** `d_rd`=`d_wr`=1 → a write is performed and `d_rdata` is unchanged. An `i_req` raised during this access is served next.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter sequencing 32-bit accesses onto a 16-bit SRAM
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        i_stall,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_stall,
    output logic [17:0] SRAMaddress,
    output logic        SRAMWEn,
    inout  wire  [15:0] SRAMdata
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;   // 1 = data port was granted last
    logic        gnt_q, gnt_d;     // 1 = data port owns the current access
    logic        wr_q, wr_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] rbuf_q, rbuf_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;

    logic d_req, phase_end, drive;
    logic unused_addr_bits;

    assign d_req     = d_rd | d_wr;
    assign phase_end = (cnt_q == CNT_LAST);
    assign unused_addr_bits = ^{i_addr[31:19], i_addr[1:0], d_addr[31:19], d_addr[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req | d_req) begin
                    gnt_d   = (i_req & d_req) ? ~last_q : d_req;
                    last_d  = gnt_d;
                    wr_d    = gnt_d & d_wr;
                    addr_d  = gnt_d ? d_addr[18:2] : i_addr[18:2];
                    wdata_d = d_wdata;
                    cnt_d   = 4'd0;
                    state_d = LO;
                end
            end
            LO: begin
                cnt_d = cnt_q + 4'd1;
                if (phase_end) begin
                    cnt_d   = 4'd0;
                    state_d = HI;
                    if (!wr_q) rbuf_d = SRAMdata;
                end
            end
            HI: begin
                cnt_d = cnt_q + 4'd1;
                if (phase_end) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                    // Ready is registered so it is high exactly during DONE.
                    if (gnt_q) d_ready_d = 1'b1;
                    else       i_ready_d = 1'b1;
                    if (!wr_q) begin
                        if (gnt_q) d_rdata_d = {SRAMdata, rbuf_q};
                        else       i_rdata_d = {SRAMdata, rbuf_q};
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_q    <= 1'b0;
            gnt_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 17'd0;
            wdata_q   <= 32'd0;
            rbuf_q    <= 16'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rbuf_q    <= rbuf_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
        end
    end

    // Write strobe and bus drive derive from state only, so reset releases them at once.
    assign drive       = wr_q & ((state_q == LO) | (state_q == HI));
    assign SRAMWEn     = ~drive;
    assign SRAMaddress = {addr_q, state_q == HI};
    assign SRAMdata    = drive ? ((state_q == HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign i_stall = i_req & ~i_ready_q;
    assign d_stall = d_req & ~d_ready_q;
endmodule
